// File: rtl/pwrseq_pkg.sv
// Shared types and constants for the ADC analog power sequencer.
// Each pwdn vector is ordered {bias, amp, cmp}, and 1 means that stage is powered down.
package pwrseq_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_OFF,
    S_UP_BIAS,
    S_UP_AMP,
    S_UP_CMP,
    S_ON,
    S_DN_CMP,
    S_DN_AMP,
    S_FAULT
  } state_t;

  typedef logic [2:0] pwdn_t;

  localparam pwdn_t PWDN_ALL     = 3'b111;
  localparam pwdn_t PWDN_BIAS_UP = 3'b011;
  localparam pwdn_t PWDN_AMP_UP  = 3'b001;
  localparam pwdn_t PWDN_NONE    = 3'b000;

  function automatic pwdn_t pwdn_of(state_t s);
    case (s)
      S_UP_BIAS, S_DN_AMP: return PWDN_BIAS_UP;
      S_UP_AMP,  S_DN_CMP: return PWDN_AMP_UP;
      S_UP_CMP,  S_ON:     return PWDN_NONE;
      default:             return PWDN_ALL;
    endcase
  endfunction

  function automatic logic is_busy(state_t s);
    return (s inside {S_UP_BIAS, S_UP_AMP, S_UP_CMP, S_DN_CMP, S_DN_AMP});
  endfunction

endpackage

// File: rtl/pwrseq_if.sv
// Bundles the request, monitor and status lines that connect the sequencer to the ADC controller.
// The master side is the controller. The slave side is the sequencer.
interface pwrseq_if;

  logic en;
  logic bias_ok;
  logic pwdn_bias;
  logic pwdn_amp;
  logic pwdn_cmp;
  logic ready;
  logic busy;
  logic fault;

  modport master (
    output en, bias_ok,
    input  pwdn_bias, pwdn_amp, pwdn_cmp, ready, busy, fault
  );

  modport slave (
    input  en, bias_ok,
    output pwdn_bias, pwdn_amp, pwdn_cmp, ready, busy, fault
  );

endinterface

// File: rtl/pwrseq_sync2.sv
// Two-flop synchronizer that brings the asynchronous bias_ok monitor into the clk domain.
// Both flops clear to 0, so the bias is treated as not good out of reset.
module pwrseq_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwr_sequencer.sv
// Orders the power-up and power-down of the ADC analog front end: bias, then opamp, then comparator.
// Defining PWRSEQ_BIAS_MON_EN gates bias settling on bias_ok and enables the FAULT state.
module pwr_sequencer
  import pwrseq_pkg::*;
#(
  parameter int unsigned BIAS_SETTLE_CYC = 16,
  parameter int unsigned AMP_SETTLE_CYC  = 8,
  parameter int unsigned CMP_SETTLE_CYC  = 4,
  parameter int unsigned DN_STEP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC     = 64
) (
  input  logic     clk,
  input  logic     rstb,
  pwrseq_if.slave  bus
);

`ifdef PWRSEQ_BIAS_MON_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  // With the monitor enabled, UP_BIAS counts down the whole timeout window.
  // In that case the settle point is reached once the count has dropped to SETTLE_MARK.
  localparam cnt_t UP_BIAS_LD  = MON_EN ? cnt_t'(TIMEOUT_CYC - 1) : cnt_t'(BIAS_SETTLE_CYC - 1);
  localparam cnt_t SETTLE_MARK = MON_EN ? cnt_t'(TIMEOUT_CYC - BIAS_SETTLE_CYC) : '0;
  localparam cnt_t AMP_LD      = cnt_t'(AMP_SETTLE_CYC - 1);
  localparam cnt_t CMP_LD      = cnt_t'(CMP_SETTLE_CYC - 1);
  localparam cnt_t DN_LD       = cnt_t'(DN_STEP_CYC - 1);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  pwdn_t  pwdn_q;
  logic   ready_q, busy_q, fault_q;

  logic   settle_done;
  logic   bias_timeout;
  logic   bias_lost;

`ifdef PWRSEQ_BIAS_MON_EN
  logic bias_ok_s;

  pwrseq_sync2 u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d_i  (bus.bias_ok),
    .q_o  (bias_ok_s)
  );

  assign settle_done  = (cnt_q <= SETTLE_MARK) && bias_ok_s;
  assign bias_timeout = (cnt_q == '0) && !bias_ok_s;
  assign bias_lost    = !bias_ok_s;
`else
  assign settle_done  = (cnt_q == SETTLE_MARK);
  assign bias_timeout = 1'b0;
  assign bias_lost    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - cnt_t'(1) : '0;
    unique case (state_q)
      S_OFF: begin
        if (bus.en) begin
          state_d = S_UP_BIAS;
          cnt_d   = UP_BIAS_LD;
        end
      end
      S_UP_BIAS: begin
        if (!bus.en) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (settle_done) begin
          state_d = S_UP_AMP;
          cnt_d   = AMP_LD;
        end else if (bias_timeout) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
      end
      S_UP_AMP: begin
        if (!bus.en) begin
          state_d = S_DN_AMP;
          cnt_d   = DN_LD;
        end else if (cnt_q == '0) begin
          state_d = S_UP_CMP;
          cnt_d   = CMP_LD;
        end
      end
      S_UP_CMP: begin
        if (!bus.en) begin
          state_d = S_DN_CMP;
          cnt_d   = DN_LD;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        // A bias collapse takes priority over an orderly ramp-down.
        if (bias_lost) begin
          state_d = S_FAULT;
        end else if (!bus.en) begin
          state_d = S_DN_CMP;
          cnt_d   = DN_LD;
        end
      end
      S_DN_CMP: begin
        if (cnt_q == '0) begin
          state_d = S_DN_AMP;
          cnt_d   = DN_LD;
        end
      end
      S_DN_AMP: begin
        if (cnt_q == '0) state_d = S_OFF;
      end
      S_FAULT: begin
        if (!bus.en) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pwdn_q  <= PWDN_ALL;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwdn_q  <= pwdn_of(state_d);
      ready_q <= (state_d == S_ON);
      busy_q  <= is_busy(state_d);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign bus.pwdn_bias = pwdn_q[2];
  assign bus.pwdn_amp  = pwdn_q[1];
  assign bus.pwdn_cmp  = pwdn_q[0];
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_pwr_sequencer.sv
// Bench for pwr_sequencer: a stage-count model checked against the DUT every cycle.
// Directed ramps with hand-counted latencies pin the model; build with PWRSEQ_BIAS_MON_EN for monitor cases.
module tb_pwr_sequencer;

`ifdef PWRSEQ_BIAS_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  localparam int SB = 5, SA = 4, SC = 3, SR = 2, SY = 1, SF = 0;
  localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3, M_FLT = 4;

  logic clk = 1'b0;
  logic rstb;
  pwrseq_if bus_if ();

  pwr_sequencer dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [5:0] obs;
  assign obs = {bus_if.pwdn_bias, bus_if.pwdn_amp, bus_if.pwdn_cmp,
                bus_if.ready, bus_if.busy, bus_if.fault};

  // The model tracks how many stages are released (0..3) and how long the current step has lasted.
  int mode = M_OFF, stages = 0, t = 0, k = 0;
  logic b1 = 1'b0, b2 = 1'b0, bs;

  always @(posedge clk) begin
    cyc++;
    bs = b2;
    b2 = b1;
    b1 = bus_if.bias_ok;
    if (!rstb) begin
      mode = M_OFF; stages = 0; t = 0; k = 0; b1 = 1'b0; b2 = 1'b0;
    end else begin
      case (mode)
        M_OFF: if (bus_if.en) begin mode = M_UP; stages = 1; t = 0; k = 0; end
        M_UP: begin
          if (!bus_if.en) begin
            if (stages == 1) begin mode = M_OFF; stages = 0; end
            else begin stages--; mode = M_DN; t = 0; end
          end else begin
            t++; k++;
            if (stages == 1) begin
              if (t >= 16 && (!MON || bs)) begin stages = 2; t = 0; end
              else if (MON && k >= 64) begin mode = M_FLT; stages = 0; end
            end else if (stages == 2 && t >= 8) begin stages = 3; t = 0; end
            else if (stages == 3 && t >= 4) mode = M_ON;
          end
        end
        M_ON: begin
          if (MON && !bs) begin mode = M_FLT; stages = 0; end
          else if (!bus_if.en) begin stages = 2; mode = M_DN; t = 0; end
        end
        M_DN: begin
          t++;
          if (t >= 2) begin stages--; t = 0; if (stages == 0) mode = M_OFF; end
        end
        default: if (!bus_if.en) mode = M_OFF;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [5:0] exp_v;
      exp_v = {stages < 1, stages < 2, stages < 3, mode == M_ON,
               (mode == M_UP) || (mode == M_DN), mode == M_FLT};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL model cyc=%0d outputs got=%b expected=%b", cyc, obs, exp_v);
      end
      tests++;
      if (!(obs[SB] <= obs[SA] && obs[SA] <= obs[SC])) begin
        fails++;
        $display("FAIL order cyc=%0d pwdn got=%b expected bias<=amp<=cmp", cyc, obs[5:3]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp_v);
    tests++;
    if (got != exp_v) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
    end else
      $display("[TB] %s = %0d ok", name, got);
  endtask

  // Counts negedges until output bit sel equals val, giving up after budget cycles.
  task automatic wait_until(input int sel, input logic val, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (obs[sel] !== val && n < budget);
    if (obs[sel] !== val) begin
      tests++;
      fails++;
      $display("FAIL timeout sel=%0d got=%b expected=%b after %0d cycles", sel, obs[sel], val, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstb = 1'b0;
    bus_if.en = 1'b1;
    bus_if.bias_ok = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pwdn", int'(obs[5:3]), 7);
    chk("reset_flags", int'(obs[2:0]), 0);
    rstb = 1'b1;

    // Full power-up from reset release.
    wait_until(SB, 1'b0, 5, n);  chk("up_bias_fall", n, 1);
    wait_until(SA, 1'b0, 40, n); chk("up_amp_delay", n, 16);
    wait_until(SC, 1'b0, 20, n); chk("up_cmp_delay", n, 8);
    wait_until(SR, 1'b1, 10, n); chk("up_ready_delay", n, 4);
    chk("on_busy", int'(obs[SY]), 0);

    // Orderly power-down from ON.
    bus_if.en = 1'b0;
    wait_until(SC, 1'b1, 5, n);  chk("dn_cmp_delay", n, 1);
    wait_until(SA, 1'b1, 5, n);  chk("dn_amp_delay", n, 2);
    wait_until(SY, 1'b0, 5, n);  chk("dn_busy_end", n, 2);
    chk("dn_bias_off", int'(obs[SB]), 1);

    // Abort during UP_AMP: the comparator is never released.
    bus_if.en = 1'b1;
    wait_until(SB, 1'b0, 5, n);
    repeat (19) @(negedge clk);
    chk("abort_amp_up", int'(obs[SA]), 0);
    bus_if.en = 1'b0;
    wait_until(SA, 1'b1, 5, n);  chk("abort_amp_dn", n, 1);
    wait_until(SB, 1'b1, 5, n);  chk("abort_bias_dn", n, 2);
    chk("abort_cmp_held", int'(obs[SC]), 1);

    // en toggling during DN_CMP completes the ramp-down, then restarts.
    bus_if.en = 1'b1;
    wait_until(SR, 1'b1, 40, n); chk("t4_ready", n, 29);
    bus_if.en = 1'b0;
    @(negedge clk);
    bus_if.en = 1'b1;
    wait_until(SB, 1'b1, 8, n);  chk("t4_down_done", n, 4);
    wait_until(SB, 1'b0, 5, n);  chk("t4_restart", n, 1);
    wait_until(SR, 1'b1, 40, n); chk("t4_ready2", n, 28);
    bus_if.en = 1'b0;
    wait_until(SY, 1'b0, 8, n);  chk("t4_off", n, 5);

    // Reset mid-sequence drops everything at once.
    bus_if.en = 1'b1;
    repeat (20) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    chk("rst_mid_pwdn", int'(obs[5:3]), 7);
    chk("rst_mid_busy", int'(obs[SY]), 0);
    rstb = 1'b1;
    bus_if.en = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PWRSEQ_BIAS_MON_EN
    // Bias never comes good: timeout to FAULT.
    bus_if.bias_ok = 1'b0;
    bus_if.en = 1'b1;
    wait_until(SB, 1'b0, 5, n);
    wait_until(SF, 1'b1, 80, n); chk("mon_timeout", n, 64);
    chk("mon_fault_pwdn", int'(obs[5:3]), 7);
    chk("mon_fault_amp_held", int'(obs[SY]), 0);
    bus_if.en = 1'b0;
    wait_until(SF, 1'b0, 5, n);  chk("mon_fault_clr", n, 1);

    // Late bias_ok, then loss of bias while ON.
    bus_if.en = 1'b1;
    wait_until(SB, 1'b0, 5, n);
    repeat (29) @(negedge clk);
    bus_if.bias_ok = 1'b1;
    wait_until(SA, 1'b0, 10, n); chk("mon_late_amp", 29 + n, 32);
    wait_until(SR, 1'b1, 20, n); chk("mon_late_ready", n, 12);
    bus_if.bias_ok = 1'b0;
    wait_until(SF, 1'b1, 6, n);  chk("mon_loss_fault", n, 3);
    bus_if.en = 1'b0;
    bus_if.bias_ok = 1'b1;
    wait_until(SF, 1'b0, 5, n);  chk("mon_loss_clr", n, 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
